// File: rtl/fb_pkg.sv
// Shared frame-buffer constants: geometry, pixel format, colours, and writer FSM encoding.
// Sized for a 128x96 buffer with 3-bit RGB111 pixels.
package fb_pkg;

  localparam int SCREEN_X = 128;
  localparam int SCREEN_Y = 96;
  localparam int AW       = 14;
  localparam int DW       = 3;
  localparam int XW       = 8;
  localparam int YW       = 7;

  localparam logic [DW-1:0] COL_BLACK = 3'b000;
  localparam logic [DW-1:0] COL_RED   = 3'b100;
  localparam logic [DW-1:0] COL_GREEN = 3'b010;
  localparam logic [DW-1:0] COL_BLUE  = 3'b001;
  localparam logic [DW-1:0] COL_WHITE = 3'b111;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CLIP = 2'd1;
  localparam logic [1:0] ST_DRAW = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // The row stride is a power of two, so a row base is a shift rather than a multiply.
  function automatic logic [AW-1:0] row_base_of(input logic [YW-1:0] y);
    return AW'(y) << $clog2(SCREEN_X);
  endfunction

endpackage

// File: rtl/fb_rect_writer_if.sv
// Command handshake plus frame-buffer write port of the rectangle writer.
// master = command issuer / RAM side, slave = the writer engine.
interface fb_rect_writer_if;
  import fb_pkg::*;

  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_clear;
  logic [XW-1:0] cmd_x;
  logic [YW-1:0] cmd_y;
  logic [XW-1:0] cmd_w;
  logic [YW-1:0] cmd_h;
  logic [DW-1:0] cmd_color;
  logic          busy;
  logic          done;
  logic [AW-1:0] mem_px_addr;
  logic [DW-1:0] mem_px_data;
  logic          px_wr;

  modport master (
    output cmd_valid, cmd_clear, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color,
    input  cmd_ready, busy, done, mem_px_addr, mem_px_data, px_wr
  );

  modport slave (
    input  cmd_valid, cmd_clear, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color,
    output cmd_ready, busy, done, mem_px_addr, mem_px_data, px_wr
  );

endinterface

// File: rtl/fb_addr_gen.sv
// Raster walker over a clipped rectangle: cx/cy/row_base counters, buffer address and last-pixel flag.
// Loaded once per command, then advanced one pixel per step.
module fb_addr_gen
  import fb_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          step,
  input  logic [XW-1:0] x0,
  input  logic [YW-1:0] y0,
  input  logic [XW-1:0] x_last,
  input  logic [YW-1:0] y_last,
  output logic [AW-1:0] addr,
  output logic          last
);

  logic [XW-1:0] cx, x0_q, xl_q;
  logic [YW-1:0] cy, yl_q;
  logic [AW-1:0] row_base;
  logic          eol;

  assign eol  = (cx == xl_q);
  assign last = eol && (cy == yl_q);
  assign addr = row_base + AW'(cx);

  always_ff @(posedge clk) begin
    if (rst) begin
      cx       <= '0;
      cy       <= '0;
      row_base <= '0;
      x0_q     <= '0;
      xl_q     <= '0;
      yl_q     <= '0;
    end else if (load) begin
      cx       <= x0;
      cy       <= y0;
      row_base <= row_base_of(y0);
      x0_q     <= x0;
      xl_q     <= x_last;
      yl_q     <= y_last;
    end else if (step) begin
      if (eol) begin
        cx       <= x0_q;
        cy       <= cy + 1'b1;
        row_base <= row_base + AW'(SCREEN_X);
      end else begin
        cx <= cx + 1'b1;
      end
    end
  end

endmodule

// File: rtl/fb_rect_writer.sv
// Rectangle-fill / screen-clear engine driving the frame-buffer write port, one clipped pixel per cycle.
// All outputs registered, so each one trails the FSM state by one cycle.
module fb_rect_writer
  import fb_pkg::*;
(
  input logic             clk,
  input logic             rst,
  fb_rect_writer_if.slave bus
);

  logic [1:0]    state;
  logic [XW-1:0] x_q, w_q;
  logic [YW-1:0] y_q, h_q;
  logic [DW-1:0] color_q;
  logic          cmd_ready_q, busy_q, done_q, px_wr_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] data_q;

  logic          accept, degen, ag_last;
  logic [8:0]    x_sum, x_end;
  logic [7:0]    y_sum, y_end;
  logic [AW-1:0] ag_addr;

  assign accept = (state == ST_IDLE) && bus.cmd_valid && cmd_ready_q;

  assign x_sum = {1'b0, x_q} + {1'b0, w_q};
  assign y_sum = {1'b0, y_q} + {1'b0, h_q};
  assign x_end = (x_sum > 9'(SCREEN_X)) ? 9'(SCREEN_X) : x_sum;
  assign y_end = (y_sum > 8'(SCREEN_Y)) ? 8'(SCREEN_Y) : y_sum;
  assign degen = (w_q == '0) || (h_q == '0) ||
                 (x_q >= 8'(SCREEN_X)) || (y_q >= 7'(SCREEN_Y));

  fb_addr_gen u_addr_gen (
    .clk    (clk),
    .rst    (rst),
    .load   ((state == ST_CLIP) && !degen),
    .step   (state == ST_DRAW),
    .x0     (x_q),
    .y0     (y_q),
    .x_last (8'(x_end - 9'd1)),
    .y_last (7'(y_end - 8'd1)),
    .addr   (ag_addr),
    .last   (ag_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      px_wr_q     <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      x_q         <= '0;
      y_q         <= '0;
      w_q         <= '0;
      h_q         <= '0;
      color_q     <= '0;
    end else begin
      // ready re-opens only one cycle after IDLE is re-entered, after the done pulse
      cmd_ready_q <= (state == ST_IDLE) && !accept;
      busy_q      <= !((state == ST_IDLE) && !accept);
      done_q      <= (state == ST_DONE);
      px_wr_q     <= (state == ST_DRAW);
      if (state == ST_DRAW) begin
        addr_q <= ag_addr;
        data_q <= color_q;
      end

      case (state)
        ST_IDLE: begin
          if (accept) begin
            color_q <= bus.cmd_color;
            if (bus.cmd_clear) begin
              x_q <= '0;
              y_q <= '0;
              w_q <= 8'(SCREEN_X);
              h_q <= 7'(SCREEN_Y);
            end else begin
              x_q <= bus.cmd_x;
              y_q <= bus.cmd_y;
              w_q <= bus.cmd_w;
              h_q <= bus.cmd_h;
            end
            state <= ST_CLIP;
          end
        end
        ST_CLIP: state <= degen ? ST_DONE : ST_DRAW;
        ST_DRAW: if (ag_last) state <= ST_DONE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.cmd_ready   = cmd_ready_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.px_wr       = px_wr_q;
  assign bus.mem_px_addr = addr_q;
  assign bus.mem_px_data = data_q;

endmodule

// File: doc/fb_rect_writer.md
Name: fb_rect_writer

Overview:
- Write-side engine for the 128x96, 3-bit-colour dual-port frame buffer whose read port is scanned by the 640x480 VGA path at 5x upscale.
- Accepts rectangle-fill and full-screen-clear commands over a valid/ready handshake.
- Emits one pixel write per cycle on the buffer write port (address, data, write strobe), clipped to the screen.
- Game logic issues commands to this block instead of driving the RAM write port directly.

Parameters:
- SCREEN_X, 128, buffer width in pixels; row stride for addressing.
- SCREEN_Y, 96, buffer height in pixels.
- AW, 14, write-address width; must satisfy 2^AW >= SCREEN_X*SCREEN_Y.
- DW, 3, pixel width, RGB 111 (bit2=R, bit1=G, bit0=B).

Ports:
- clk  in  1  pixel clock (25 MHz domain); shared with the RAM write clock.
- rst  in  1  synchronous reset, active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command.
- cmd_clear  in  1  1 = fill the whole screen; x/y/w/h are ignored.
- cmd_x  in  8  left column (0..255; values >= SCREEN_X are off-screen).
- cmd_y  in  7  top row (0..127; values >= SCREEN_Y are off-screen).
- cmd_w  in  8  width in pixels.
- cmd_h  in  7  height in pixels.
- cmd_color  in  DW  fill colour.
- busy  out  1  command in progress.
- done  out  1  one-cycle pulse when a command completes.
- mem_px_addr  out  AW  buffer write address.
- mem_px_data  out  DW  buffer write data.
- px_wr  out  1  buffer write strobe.

Behaviour:
- Clocking and reset: one clock, clk; synchronous active-high reset rst.
- Reset values: state=IDLE, cmd_ready=1, busy=0, done=0, px_wr=0, mem_px_addr=0, mem_px_data=0. All outputs are registered.
- FSM states: IDLE, CLIP, DRAW, DONE.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid && cmd_ready, latch all command fields (cycle 0) and go to CLIP.
  - cmd_ready=0 and busy=1 in every other state. cmd_valid is ignored while busy; commands are not queued.
- Clear substitution: if cmd_clear=1 the latched fields become x=0, y=0, w=SCREEN_X, h=SCREEN_Y.
- CLIP (cycle 1):
  - x_end = min(x+w, SCREEN_X), computed 9-bit.
  - y_end = min(y+h, SCREEN_Y), computed 8-bit.
  - If w==0, h==0, x>=SCREEN_X or y>=SCREEN_Y, go to DONE with zero writes.
  - Otherwise set cx=x, cy=y, row_base=y*SCREEN_X, and go to DRAW.
  - row_base is computed by an add-accumulate or shift; no general multiplier.
- DRAW (first write visible at cycle 2):
  - Each cycle: px_wr=1, mem_px_addr=row_base+cx, mem_px_data=colour.
  - cx increments every cycle.
  - When cx==x_end-1: cx returns to x, cy increments, and row_base += SCREEN_X.
  - After the write with cx==x_end-1 and cy==y_end-1, go to DONE.
  - The write count equals the clipped w*h. Wrap-around into the next row never occurs: clipping is exact.
- DONE: done=1 and px_wr=0 for one cycle, then IDLE with cmd_ready=1 on the following cycle.
- Latency for an n-pixel command:
  - writes occupy cycles 2..n+1;
  - done is high at cycle n+2;
  - the next command is accepted no earlier than cycle n+3.
- px_wr=0 in IDLE, CLIP and DONE; mem_px_addr and mem_px_data hold their last value there.
- Reset mid-operation: on the next edge the block is in IDLE and px_wr=0. No partial-row completion and no done pulse.
- Simultaneous rst and cmd_valid: reset wins; the command is not accepted.

Decomposition:
- Shared package fb_pkg holds:
  - SCREEN_X, SCREEN_Y, AW, DW;
  - colour constants COL_BLACK=3'b000, COL_RED=3'b100, COL_GREEN=3'b010, COL_BLUE=3'b001, COL_WHITE=3'b111;
  - the state encoding.
- One natural sub-module, fb_addr_gen: the cx/cy/row_base counter with a last-pixel flag. The FSM stays in fb_rect_writer.

Test Plan:
- Reset check: assert rst for 3 cycles, then release -> cmd_ready=1, busy=0, done=0, px_wr=0, mem_px_addr=0.
- Single pixel: x=5, y=3, w=1, h=1, colour=3'b101 accepted at cycle 0 -> exactly one px_wr at cycle 2 with addr=389, data=3'b101; done at cycle 3; cmd_ready=1 at cycle 4.
- Corner clip: x=126, y=94, w=4, h=4, colour=3'b010 -> exactly 4 writes, in order, to addr 12158, 12159, 12286, 12287; then done.
- Clear: cmd_clear=1, colour=3'b000, with junk on x/y/w/h -> 12288 consecutive writes at addresses 0..12287 in order; done at cycle 12290.
- Degenerate commands: w=0 (also x=200, and y=100 as separate cases) -> no px_wr; done at cycle 2; cmd_valid held high during busy causes no second command.
- Reset mid-draw: 10x10 rectangle, rst asserted after the 37th write -> px_wr=0 from the next edge, no done pulse, cmd_ready=1 after reset release.
